// File: rtl/updown_counter_pkg.sv
// Shared types and the step/next-value function for updown_counter_multimode.
package updown_counter_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned MAX_W  = 32;

  typedef enum logic [MODE_W-1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RELOAD  = 2'd3
  } cnt_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } cnt_state_e;

  typedef struct packed {
    logic [MAX_W-1:0] nxt;
    logic             clamp;
    logic             ovf;
    logic             unf;
  } step_res_t;

  // Operands are zero-extended to MAX_W; maxv is the all-ones value of the caller's width.
  function automatic step_res_t cnt_step(
    input logic [MAX_W-1:0] cnt,
    input logic [MAX_W-1:0] tgt,
    input logic [MAX_W-1:0] rld,
    input logic [MAX_W-1:0] maxv,
    input cnt_mode_e        md,
    input logic             up
  );
    step_res_t r;
    r = '0;
    if (md == MODE_RELOAD && cnt == tgt) begin
      r.nxt = rld;
    end else if (up) begin
      if (cnt == maxv) begin
        r.ovf   = 1'b1;
        r.clamp = (md == MODE_SAT);
        r.nxt   = (md == MODE_SAT) ? cnt : '0;
      end else begin
        r.nxt = cnt + MAX_W'(1);
      end
    end else begin
      if (cnt == '0) begin
        r.unf   = 1'b1;
        r.clamp = (md == MODE_SAT);
        r.nxt   = (md == MODE_SAT) ? cnt : maxv;
      end else begin
        r.nxt = cnt - MAX_W'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_counter_multimode.sv
// Multi-mode up/down counter with target compare and run-control FSM.
// Optional sticky ovf/unf status: define UPDOWN_COUNTER_STATUS_EN.
module updown_counter_multimode
  import updown_counter_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TARGET_RST = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             target_we,
  input  logic [WIDTH-1:0] target_in,
  input  logic             enable,
  input  logic             inc,
  input  logic             dec,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             running,
`ifdef UPDOWN_COUNTER_STATUS_EN
  input  logic             status_clr,
  output logic             ovf,
  output logic             unf,
`endif
  output logic             halted
);

  localparam logic [MAX_W-1:0] MAX_VAL = MAX_W'({WIDTH{1'b1}});

  cnt_state_e       r_state;
  cnt_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] r_target;
  logic             r_done;
  logic             w_step;
  logic             w_hit;
  cnt_mode_e        w_mode;
  step_res_t        w_res;

  assign w_mode = cnt_mode_e'(mode);
  assign w_step = (r_state == ST_RUN) && enable && (inc ^ dec);
  assign w_res  = cnt_step(MAX_W'(r_count), MAX_W'(r_target), MAX_W'(r_reload),
                           MAX_VAL, w_mode, inc);
  // A clamped SAT step does not move, so it must not re-raise done at target.
  assign w_hit  = w_step && !w_res.clamp && (w_res.nxt == MAX_W'(r_target));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (load) w_state_nxt = ST_RUN;
      ST_RUN:  if (!load && w_hit && w_mode == MODE_ONESHOT) w_state_nxt = ST_HALT;
      ST_HALT: if (load) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else if (load) begin
      r_count  <= din;
      r_reload <= din;
      r_done   <= 1'b0;
    end else if (w_step) begin
      r_count  <= w_res.nxt[WIDTH-1:0];
      r_done   <= w_hit;
    end else begin
      r_done   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_target <= TARGET_RST;
    else if (target_we) r_target <= target_in;
  end

`ifdef UPDOWN_COUNTER_STATUS_EN
  logic r_ovf;
  logic r_unf;
  logic w_ovf_set;
  logic w_unf_set;

  assign w_ovf_set = !load && w_step && w_res.ovf;
  assign w_unf_set = !load && w_step && w_res.unf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~status_clr);
      r_unf <= w_unf_set | (r_unf & ~status_clr);
    end
  end

  assign ovf = r_ovf;
  assign unf = r_unf;
`else
  logic w_unused_flags;
  assign w_unused_flags = w_res.ovf | w_res.unf;
`endif

  assign count   = r_count;
  assign done    = r_done;
  assign running = (r_state == ST_RUN);
  assign halted  = (r_state == ST_HALT);

endmodule

// File: tb/tb_updown_counter_multimode.sv
// Scoreboard bench for updown_counter_multimode (WIDTH=8); status checks when UPDOWN_COUNTER_STATUS_EN is defined.
module tb_updown_counter_multimode;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [7:0] din;
  logic       target_we;
  logic [7:0] target_in;
  logic       enable;
  logic       inc;
  logic       dec;
  logic [1:0] mode;
  logic [7:0] count;
  logic       done;
  logic       running;
  logic       halted;
`ifdef UPDOWN_COUNTER_STATUS_EN
  logic       status_clr;
  logic       ovf;
  logic       unf;
  logic       p_clr;
`endif

  updown_counter_multimode #(.WIDTH(8), .TARGET_RST(8'hFF)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .din       (din),
    .target_we (target_we),
    .target_in (target_in),
    .enable    (enable),
    .inc       (inc),
    .dec       (dec),
    .mode      (mode),
    .count     (count),
    .done      (done),
    .running   (running),
`ifdef UPDOWN_COUNTER_STATUS_EN
    .status_clr(status_clr),
    .ovf       (ovf),
    .unf       (unf),
`endif
    .halted    (halted)
  );

  typedef struct {
    string      nm;
    logic [7:0] cnt;
    logic       dn;
    logic       run;
    logic       hlt;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t q[$];
  event ev_now;
  int   checks = 0;
  int   errors = 0;

  logic       p_twe = 1'b0;
  logic [7:0] p_tin = '0;
  logic       x_ovf = 1'b0;
  logic       x_unf = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: compares after every rising edge, or immediately on ev_now.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or ev_now);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (count !== e.cnt || done !== e.dn || running !== e.run || halted !== e.hlt) begin
          errors++;
          $display("FAIL %s: got cnt=%h done=%b run=%b halt=%b, want cnt=%h done=%b run=%b halt=%b",
                   e.nm, count, done, running, halted, e.cnt, e.dn, e.run, e.hlt);
        end
`ifdef UPDOWN_COUNTER_STATUS_EN
        checks++;
        if (ovf !== e.ov || unf !== e.un) begin
          errors++;
          $display("FAIL %s_status: got ovf=%b unf=%b, want ovf=%b unf=%b",
                   e.nm, ovf, unf, e.ov, e.un);
        end
`endif
      end
    end
  end

  task automatic clr_next();
`ifdef UPDOWN_COUNTER_STATUS_EN
    p_clr = 1'b1;
`endif
  endtask

  task automatic push(input string nm, input logic [7:0] ec, input logic ed,
                      input logic er, input logic eh);
    exp_t e;
    e.nm = nm; e.cnt = ec; e.dn = ed; e.run = er; e.hlt = eh;
    e.ov = x_ovf; e.un = x_unf;
    q.push_back(e);
  endtask

  // Drives one cycle of inputs at the falling edge and queues the post-edge expectation.
  task automatic step(input string nm, input logic ld, input logic [7:0] d,
                      input logic en, input logic i, input logic dd, input logic [1:0] md,
                      input logic [7:0] ec, input logic ed, input logic er, input logic eh);
    @(negedge clk);
    load = ld; din = d; enable = en; inc = i; dec = dd; mode = md;
    target_we = p_twe; target_in = p_tin;
`ifdef UPDOWN_COUNTER_STATUS_EN
    status_clr = p_clr;
    p_clr = 1'b0;
`endif
    p_twe = 1'b0;
    push(nm, ec, ed, er, eh);
  endtask

  task automatic idle_inputs();
    load = 0; din = '0; target_we = 0; target_in = '0; enable = 0; inc = 0; dec = 0; mode = '0;
`ifdef UPDOWN_COUNTER_STATUS_EN
    status_clr = 0;
`endif
  endtask

  initial begin
`ifdef UPDOWN_COUNTER_STATUS_EN
    p_clr = 1'b0;
`endif
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    //                          ld din   en i  d  md    cnt   dn run hlt
    step("idle_inc",            0, 8'h00, 1, 1, 0, 2'd0, 8'h00, 0, 0, 0);
    step("ld_fe",               1, 8'hFE, 0, 0, 0, 2'd0, 8'hFE, 0, 1, 0);
    step("tgt_rst_ff",          0, 8'h00, 1, 1, 0, 2'd0, 8'hFF, 1, 1, 0);
    x_ovf = 1;
    step("wrap_ff_00",          0, 8'h00, 1, 1, 0, 2'd0, 8'h00, 0, 1, 0);

    p_twe = 1; p_tin = 8'h00; clr_next(); x_ovf = 0;
    step("wrap_ld_fe",          1, 8'hFE, 0, 0, 0, 2'd0, 8'hFE, 0, 1, 0);
    step("wrap_inc1",           0, 8'h00, 1, 1, 0, 2'd0, 8'hFF, 0, 1, 0);
    x_ovf = 1;
    step("wrap_inc2",           0, 8'h00, 1, 1, 0, 2'd0, 8'h00, 1, 1, 0);
    step("inc_and_dec",         0, 8'h00, 1, 1, 1, 2'd0, 8'h00, 0, 1, 0);
    step("no_enable",           0, 8'h00, 0, 1, 0, 2'd0, 8'h00, 0, 1, 0);

    p_twe = 1; p_tin = 8'h80; clr_next(); x_ovf = 0;
    step("sat_ld_01",           1, 8'h01, 0, 0, 0, 2'd1, 8'h01, 0, 1, 0);
    step("sat_dec1",            0, 8'h00, 1, 0, 1, 2'd1, 8'h00, 0, 1, 0);
    x_unf = 1;
    step("sat_dec2_clamp",      0, 8'h00, 1, 0, 1, 2'd1, 8'h00, 0, 1, 0);
    clr_next();
    step("sat_dec3_set_wins",   0, 8'h00, 1, 0, 1, 2'd1, 8'h00, 0, 1, 0);
    clr_next(); x_unf = 0;
    step("status_clr",          0, 8'h00, 0, 0, 0, 2'd1, 8'h00, 0, 1, 0);
    p_twe = 1; p_tin = 8'hFF;
    step("sat_ld_fe",           1, 8'hFE, 0, 0, 0, 2'd1, 8'hFE, 0, 1, 0);
    step("sat_hit_ff",          0, 8'h00, 1, 1, 0, 2'd1, 8'hFF, 1, 1, 0);
    x_ovf = 1;
    step("sat_clamp_no_done",   0, 8'h00, 1, 1, 0, 2'd1, 8'hFF, 0, 1, 0);

    p_twe = 1; p_tin = 8'h13; clr_next(); x_ovf = 0;
    step("os_ld_10",            1, 8'h10, 0, 0, 0, 2'd2, 8'h10, 0, 1, 0);
    step("os_inc1",             0, 8'h00, 1, 1, 0, 2'd2, 8'h11, 0, 1, 0);
    step("os_inc2",             0, 8'h00, 1, 1, 0, 2'd2, 8'h12, 0, 1, 0);
    step("os_inc3_halt",        0, 8'h00, 1, 1, 0, 2'd2, 8'h13, 1, 0, 1);
    step("os_inc4_held",        0, 8'h00, 1, 1, 0, 2'd2, 8'h13, 0, 0, 1);
    step("os_inc5_held",        0, 8'h00, 1, 1, 0, 2'd2, 8'h13, 0, 0, 1);
    step("os_reload_run",       1, 8'h00, 0, 0, 0, 2'd2, 8'h00, 0, 1, 0);

    p_twe = 1; p_tin = 8'h07;
    step("rl_ld_05",            1, 8'h05, 0, 0, 0, 2'd3, 8'h05, 0, 1, 0);
    step("rl_06a",              0, 8'h00, 1, 1, 0, 2'd3, 8'h06, 0, 1, 0);
    step("rl_07a",              0, 8'h00, 1, 1, 0, 2'd3, 8'h07, 1, 1, 0);
    step("rl_05a",              0, 8'h00, 1, 1, 0, 2'd3, 8'h05, 0, 1, 0);
    step("rl_06b",              0, 8'h00, 1, 1, 0, 2'd3, 8'h06, 0, 1, 0);
    step("rl_07b",              0, 8'h00, 1, 1, 0, 2'd3, 8'h07, 1, 1, 0);
    step("rl_05b",              0, 8'h00, 1, 1, 0, 2'd3, 8'h05, 0, 1, 0);

    step("load_beats_step",     1, 8'h40, 1, 1, 0, 2'd0, 8'h40, 0, 1, 0);
    step("load_eq_tgt_no_done", 1, 8'h07, 0, 0, 0, 2'd0, 8'h07, 0, 1, 0);
    step("ld_06",               1, 8'h06, 0, 0, 0, 2'd0, 8'h06, 0, 1, 0);
    p_twe = 1; p_tin = 8'h20;
    step("twe_old_tgt_hit",     0, 8'h00, 1, 1, 0, 2'd0, 8'h07, 1, 1, 0);
    step("twe_after_08",        0, 8'h00, 1, 1, 0, 2'd0, 8'h08, 0, 1, 0);
    step("ld_1e",               1, 8'h1E, 0, 0, 0, 2'd0, 8'h1E, 0, 1, 0);
    step("new_tgt_1f",          0, 8'h00, 1, 1, 0, 2'd0, 8'h1F, 0, 1, 0);
    step("new_tgt_hit_20",      0, 8'h00, 1, 1, 0, 2'd0, 8'h20, 1, 1, 0);

    step("wrap_ld_00",          1, 8'h00, 0, 0, 0, 2'd0, 8'h00, 0, 1, 0);
    x_unf = 1;
    step("wrap_dec_00_ff",      0, 8'h00, 1, 0, 1, 2'd0, 8'hFF, 0, 1, 0);
    step("pre_rst_ld_1f",       1, 8'h1F, 0, 0, 0, 2'd0, 8'h1F, 0, 1, 0);
    step("pre_rst_done",        0, 8'h00, 1, 1, 0, 2'd0, 8'h20, 1, 1, 0);

    // Asynchronous reset while done is high, checked before any clock edge.
    @(negedge clk);
    idle_inputs();
    #2 reset_n = 1'b0;
    x_ovf = 0; x_unf = 0;
    push("async_reset", 8'h00, 0, 0, 0);
    -> ev_now;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    step("post_rst_idle_inc",   0, 8'h00, 1, 1, 0, 2'd0, 8'h00, 0, 0, 0);
    step("post_rst_ld_fe",      1, 8'hFE, 0, 0, 0, 2'd0, 8'hFE, 0, 1, 0);
    step("post_rst_tgt_ff",     0, 8'h00, 1, 1, 0, 2'd0, 8'hFF, 1, 1, 0);

    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
